// File: rtl/rv_net_arb_if.sv
// rv_net_arb_if: requester-side and network-side streams
// of the packet arbiter, plus its status outputs.
interface rv_net_arb_if #(
    parameter int N_PORTS = 4,
    parameter int WIDTH   = 8
);
    logic [N_PORTS*WIDTH-1:0] t_dat;
    logic [N_PORTS-1:0]       t_valid;
    logic [N_PORTS-1:0]       t_ready;
    logic [WIDTH-1:0]         i_dat;
    logic                     i_valid;
    logic                     i_ready;
    logic [N_PORTS-1:0]       grant;
    logic                     busy;
    logic [15:0]              pkt_cnt;

    modport slave (
        input  t_dat, t_valid, i_ready,
        output t_ready, i_dat, i_valid,
        output grant, busy, pkt_cnt
    );

    modport master (
        output t_dat, t_valid, i_ready,
        input  t_ready, i_dat, i_valid,
        input  grant, busy, pkt_cnt
    );
endinterface

// File: rtl/rv_net_arb.sv
// rv_net_arb: packet-level round-robin arbiter.
// A grant spans header, length and payload beats.
module rv_net_arb #(
    parameter int N_PORTS = 4,
    parameter int WIDTH   = 8
) (
    input  logic          clock,
    input  logic          reset,
    rv_net_arb_if.slave   bus
);
    localparam int IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        LEN,
        BODY
    } state_t;

    state_t             state_q, state_d;
    logic [N_PORTS-1:0] grant_q, grant_d;
    logic [IW-1:0]      own_q, own_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [15:0]        pkt_cnt_q;
    logic [15:0]        pkt_cnt_d;
    logic [IW-1:0]      pick;
    logic               pick_vld;
    logic               owned;
    logic               xfer;
    logic               done;

    assign owned = (state_q != IDLE);

    // Owner's stream is wired straight through; others see ready=0.
    assign bus.i_dat   = owned ?
                         bus.t_dat[own_q*WIDTH +: WIDTH] : '0;
    assign bus.i_valid = owned & bus.t_valid[own_q];
    assign bus.t_ready = grant_q & {N_PORTS{bus.i_ready}};
    assign bus.grant   = grant_q;
    assign bus.busy    = owned;
    assign bus.pkt_cnt = pkt_cnt_q;

    assign xfer      = bus.i_valid & bus.i_ready;
    assign pkt_cnt_d = pkt_cnt_q + {15'd0, done};

    // First valid requester at or after rr, wrapping.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            int j;
            j = int'(rr_q) + i;
            if (j >= N_PORTS) j = j - N_PORTS;
            if (bus.t_valid[j]) begin
                pick     = IW'(j);
                pick_vld = 1'b1;
            end
        end
    end

    // Next state: arbitrate in IDLE, count beats while owned.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        own_d   = own_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d       = HDR;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    own_d         = pick;
                end
            end
            HDR: begin
                if (xfer) state_d = LEN;
            end
            LEN: begin
                if (xfer) begin
                    cnt_d = bus.i_dat[7:0];
                    if (bus.i_dat[7:0] == 8'd0) begin
                        done = 1'b1;
                    end else begin
                        state_d = BODY;
                    end
                end
            end
            BODY: begin
                if (xfer) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (done) begin
            state_d = IDLE;
            grant_d = '0;
            if (int'(own_q) == N_PORTS - 1) begin
                rr_d = '0;
            end else begin
                rr_d = own_q + IW'(1);
            end
        end
    end

    // State registers; reset abandons any packet in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            own_q     <= '0;
            rr_q      <= '0;
            cnt_q     <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            own_q     <= own_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end
endmodule

// File: tb/tb_rv_net_arb.sv
// tb_rv_net_arb: directed checks of the packet arbiter
// (latency, round-robin order, stalls, wrap, async reset).
module tb_rv_net_arb;
    localparam int N = 4;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pd [N];
    logic       pv [N];
    logic       rdy_fix;
    logic       rnd;
    int         n_tests = 0;
    int         n_fail  = 0;

    int         bq [$];
    int         ol [$];
    int         eq [$];
    logic [3:0] prev_g = '0;

    rv_net_arb_if #(.N_PORTS(N), .WIDTH(W)) bus ();

    rv_net_arb #(.N_PORTS(N), .WIDTH(W)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.t_dat   = '0;
        bus.t_valid = '0;
        for (int k = 0; k < N; k++) begin
            bus.t_dat[k*W +: W] = pd[k];
            bus.t_valid[k]      = pv[k];
        end
    end

    always @(posedge clk) begin
        #1;
        bus.i_ready = rnd ? ($urandom_range(0, 1) != 0)
                          : rdy_fix;
    end

    function automatic int oh2i(input logic [3:0] g);
        int r;
        r = -1;
        for (int k = 0; k < N; k++)
            if (g[k]) r = k;
        return r;
    endfunction

    // Beats are logged as {port, data}; owners on each new grant.
    always @(negedge clk) begin
        if (rst_n && bus.i_valid && bus.i_ready)
            bq.push_back((oh2i(bus.grant) << 8) | int'(bus.i_dat));
        if (bus.grant != 4'd0 && prev_g == 4'd0)
            ol.push_back(oh2i(bus.grant));
        prev_g = bus.grant;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_pkt(input int p, input logic [7:0] h,
                              input logic [7:0] l,
                              input logic [7:0] b);
        eq.push_back((p << 8) | int'(h));
        eq.push_back((p << 8) | int'(l));
        for (int k = 0; k < int'(l); k++)
            eq.push_back((p << 8) | int'(8'(b + 8'(k))));
    endtask

    task automatic chk_beats(input string tag, input int s);
        chk({tag, "_n"}, bq.size() - s, eq.size());
        for (int k = 0; k < eq.size(); k++) begin
            if (s + k < bq.size())
                chk($sformatf("%s_%0d", tag, k), bq[s+k], eq[k]);
        end
        eq.delete();
    endtask

    task automatic send(input int p, input logic [7:0] h,
                        input logic [7:0] l, input logic [7:0] b,
                        input int gap);
        int nb;
        int to;
        logic [7:0] v;
        nb = int'(l) + 2;
        for (int i = 0; i < nb; i++) begin
            if (i == 0) v = h;
            else if (i == 1) v = l;
            else v = 8'(b + 8'(i - 2));
            if (gap >= 0 && i - 2 == gap) begin
                pv[p] = 1'b0;
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
            end
            pd[p] = v;
            pv[p] = 1'b1;
            to = 0;
            forever begin
                @(negedge clk);
                if (bus.t_ready[p]) break;
                to++;
                if (to > 2000) break;
            end
            if (to > 2000) begin
                n_tests++;
                n_fail++;
                $display("FAIL timeout port %0d beat %0d", p, i);
                pv[p] = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        pv[p] = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int s;
        int os;
        rst_n   = 1'b0;
        rdy_fix = 1'b1;
        rnd     = 1'b0;
        for (int k = 0; k < N; k++) begin
            pd[k] = '0;
            pv[k] = 1'b0;
        end
        pv[0] = 1'b1;
        pd[0] = 8'h5A;
        #3;
        chk("rst_grant", bus.grant, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_cnt", bus.pkt_cnt, 0);
        chk("rst_ival", bus.i_valid, 0);
        chk("rst_trdy", bus.t_ready, 0);
        chk("rst_idat", bus.i_dat, 0);
        pv[0] = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single port 2 packet {01,03,0A,0B,0C}
        s = bq.size();
        fork
            send(2, 8'h01, 8'h03, 8'h0A, -1);
            begin
                @(negedge clk);
                chk("t1_lat0", bus.grant, 0);
                @(negedge clk);
                chk("t1_grant", bus.grant, 4'b0100);
                chk("t1_hdr", bus.i_dat, 8'h01);
            end
        join
        @(negedge clk);
        chk("t1_busy", bus.busy, 0);
        chk("t1_gnt0", bus.grant, 0);
        chk("t1_pcnt", bus.pkt_cnt, 1);
        expect_pkt(2, 8'h01, 8'h03, 8'h0A);
        chk_beats("t1", s);
        @(posedge clk);
        #1;

        // ports 0,1,3 from reset, then 0 again
        do_reset();
        s  = bq.size();
        os = ol.size();
        fork
            begin
                send(0, 8'hA0, 8'h01, 8'hB0, -1);
                send(0, 8'hA4, 8'h01, 8'hB4, -1);
            end
            send(1, 8'hA1, 8'h01, 8'hB1, -1);
            send(3, 8'hA3, 8'h01, 8'hB3, -1);
        join
        @(negedge clk);
        chk("t2_nown", ol.size() - os, 4);
        chk("t2_o0", ol[os+0], 0);
        chk("t2_o1", ol[os+1], 1);
        chk("t2_o2", ol[os+2], 3);
        chk("t2_o3", ol[os+3], 0);
        expect_pkt(0, 8'hA0, 8'h01, 8'hB0);
        expect_pkt(1, 8'hA1, 8'h01, 8'hB1);
        expect_pkt(3, 8'hA3, 8'h01, 8'hB3);
        expect_pkt(0, 8'hA4, 8'h01, 8'hB4);
        chk_beats("t2", s);
        chk("t2_pcnt", bus.pkt_cnt, 4);
        @(posedge clk);
        #1;

        // zero-length packet on port 1
        s = bq.size();
        send(1, 8'h05, 8'h00, 8'h00, -1);
        @(negedge clk);
        chk("t3_gnt0", bus.grant, 0);
        chk("t3_pcnt", bus.pkt_cnt, 5);
        expect_pkt(1, 8'h05, 8'h00, 8'h00);
        chk_beats("t3", s);
        @(posedge clk);
        #1;

        // owner stalls mid-body, port 0 waits, random ready
        s   = bq.size();
        os  = ol.size();
        rnd = 1'b1;
        fork
            send(2, 8'h20, 8'h06, 8'h50, 2);
            begin
                repeat (4) begin
                    @(posedge clk);
                    #1;
                end
                send(0, 8'h0F, 8'h01, 8'h70, -1);
            end
        join
        rnd = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t4_o0", ol[os+0], 2);
        chk("t4_o1", ol[os+1], 0);
        chk("t4_pcnt", bus.pkt_cnt, 7);
        expect_pkt(2, 8'h20, 8'h06, 8'h50);
        expect_pkt(0, 8'h0F, 8'h01, 8'h70);
        chk_beats("t4", s);
        @(posedge clk);
        #1;

        // maximum length packet on port 3
        s = bq.size();
        send(3, 8'h33, 8'hFF, 8'h00, -1);
        @(negedge clk);
        chk("t5_n", bq.size() - s, 257);
        chk("t5_pcnt", bus.pkt_cnt, 8);
        expect_pkt(3, 8'h33, 8'hFF, 8'h00);
        chk_beats("t5", s);
        @(posedge clk);
        #1;

        // preset counter to 0xFFFF, next packet wraps it
        force dut.pkt_cnt_d = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.pkt_cnt_d;
        @(negedge clk);
        chk("t5_pre", bus.pkt_cnt, 16'hFFFF);
        @(posedge clk);
        #1;
        send(2, 8'h44, 8'h00, 8'h00, -1);
        @(negedge clk);
        chk("t5_wrap", bus.pkt_cnt, 0);
        @(posedge clk);
        #1;

        // async reset in BODY with cnt=4
        pd[1] = 8'h11;
        pv[1] = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        pd[1] = 8'h06;
        @(posedge clk);
        #1;
        pd[1] = 8'h90;
        @(posedge clk);
        #1;
        pd[1] = 8'h91;
        @(posedge clk);
        #1;
        chk("t6_busy", bus.busy, 1);
        chk("t6_grant", bus.grant, 4'b0010);
        chk("t6_cnt4", dut.cnt_q, 4);
        pd[3] = 8'h33;
        pv[3] = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("t6_gnt", bus.grant, 0);
        chk("t6_bsy", bus.busy, 0);
        chk("t6_ival", bus.i_valid, 0);
        chk("t6_trdy", bus.t_ready, 0);
        chk("t6_idat", bus.i_dat, 0);
        chk("t6_pcnt", bus.pkt_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pd[1] = 8'h12;
        @(negedge clk);
        chk("t6_lat", bus.grant, 0);
        @(negedge clk);
        chk("t6_rr0", bus.grant, 4'b0010);
        chk("t6_hdr", bus.i_dat, 8'h12);
        pv[1] = 1'b0;
        pv[3] = 1'b0;
        rst_n = 1'b0;
        #2;

        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end
endmodule
